// File: rtl/clk_sw_pkg.sv
// clk_sw_pkg: shared FSM encodings, source constants and counter sizing for the clock switch controller
package clk_sw_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, ACK = 2'd2, DWELL = 2'd3} state_t;
  localparam logic SRC_A = 1'b1;
  localparam logic SRC_B = 1'b0;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/clk_sw_rr_arb.sv
// clk_sw_rr_arb: combinational round-robin pick of the lowest requester at or after ptr, wrapping
module clk_sw_rr_arb #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    valid = 1'b0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx = j;
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: arbitrates source-change requests, drives the glitch-free switch select,
// waits out the handover, acknowledges the winner and enforces a dwell before the next switch
module clk_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int   NUM_REQ       = 4,
  parameter int   SETTLE_CYCLES = 8,
  parameter int   MIN_DWELL     = 4,
  parameter logic RST_SEL       = SRC_B
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_src,
  output logic [NUM_REQ-1:0] gnt,
  output logic               sel,
  output logic               cur_src,
  output logic               busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(SETTLE_CYCLES, MIN_DWELL);
  state_t state, nxt;
  logic [IW-1:0] ptr, idx_q, a_idx;
  logic [NUM_REQ-1:0] a_gnt, gnt_d;
  logic a_valid, tgt_c, tgt_q, sw_q;
  logic [CW-1:0] cnt;
  clk_sw_rr_arb #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req(req), .ptr(ptr), .gnt(a_gnt), .idx(a_idx), .valid(a_valid)
  );
  assign tgt_c = req_src[a_idx];
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = a_valid ? ((tgt_c != cur_src) ? SETTLE : ACK) : IDLE;
      SETTLE:  nxt = (cnt == '0) ? ACK : SETTLE;
      ACK:     nxt = (sw_q && MIN_DWELL > 0) ? DWELL : IDLE;
      default: nxt = (cnt == '0) ? IDLE : DWELL;
    endcase
  end
  // grant comes from the live pick on a same-source pass, else from the captured index
  always_comb begin
    gnt_d = (nxt == ACK) ? ((state == IDLE) ? a_gnt : NUM_REQ'(1) << idx_q) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= RST_SEL;
      cur_src <= RST_SEL;
      gnt <= '0;
      busy <= 1'b0;
      ptr <= '0;
      cnt <= '0;
      idx_q <= '0;
      tgt_q <= RST_SEL;
      sw_q <= 1'b0;
    end else begin
      gnt <= gnt_d;
      busy <= nxt != IDLE;
      if (state == IDLE && a_valid) begin
        idx_q <= a_idx;
        tgt_q <= tgt_c;
        sw_q <= tgt_c != cur_src;
        if (tgt_c != cur_src) begin
          sel <= tgt_c;
          cnt <= CW'(SETTLE_CYCLES - 1);
        end
      end
      if (state == SETTLE || state == DWELL) cnt <= (cnt == '0) ? '0 : cnt - 1'b1;
      if (state == SETTLE && cnt == '0) cur_src <= tgt_q;
      if (state == ACK) begin
        ptr <= (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        if (sw_q && MIN_DWELL > 0) cnt <= CW'(MIN_DWELL - 1);
      end
    end
  end
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: directed stimulus with a grant scoreboard checked by an independent monitor
module tb_clk_switch_ctrl;
  import clk_sw_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req, req_src, gnt;
  logic sel, cur_src, busy;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {int cyc; logic [3:0] gnt; logic src;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  clk_switch_ctrl #(.NUM_REQ(4), .SETTLE_CYCLES(8), .MIN_DWELL(4), .RST_SEL(1'b0)) dut (
    .clk(clk), .rst(rst), .req(req), .req_src(req_src),
    .gnt(gnt), .sel(sel), .cur_src(cur_src), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic expect_gnt(input int c, input logic [3:0] g, input logic s);
    sbq.push_back('{c, g, s});
  endtask

  always @(negedge clk) begin
    if (gnt !== 4'b0) begin
      if (sbq.size() == 0) chk("unexpected_gnt", gnt, 0);
      else begin
        mon_e = sbq.pop_front();
        chk("gnt_val", gnt, mon_e.gnt);
        chk("gnt_cycle", cyc, mon_e.cyc);
        chk("gnt_cur_src", cur_src, mon_e.src);
      end
    end
  end

  task automatic chk_idle(input string name);
    chk({name, "_sel"}, sel, 0);
    chk({name, "_cur_src"}, cur_src, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_gnt"}, gnt, 0);
  endtask

  task automatic do_switch(input int i, input logic s, input int drop_k);
    int c0;
    c0 = cyc;
    req[i] = 1'b1;
    req_src[i] = s;
    expect_gnt(c0 + 9, 4'b0001 << i, s);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("sw_sel", sel, s);
      chk("sw_busy", busy, k <= 13);
      chk("sw_cur_src", cur_src, (k >= 9) ? s : !s);
      if (k == drop_k) req[i] = 1'b0;
    end
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    req = 4'($urandom);
    req_src = 4'($urandom);
    repeat (2) begin
      @(negedge clk);
      chk_idle("rst");
      req = 4'($urandom);
      req_src = 4'($urandom);
    end
    rst = 1'b0;
    req = 4'b0;
    req_src = 4'b0;
    @(negedge clk);
    chk_idle("post_rst");
    // same-source request: immediate grant, no sel movement
    c0 = cyc;
    req = 4'b0100;
    expect_gnt(c0 + 1, 4'b0100, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("same_sel", sel, 0);
      chk("same_busy", busy, k == 1);
      if (k == 1) req = 4'b0;
    end
    do_switch(1, 1'b1, 9);
    do_switch(1, 1'b0, 3);
    // reset in the middle of a settle period abandons the switch
    req[3] = 1'b1;
    req_src[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("mid_sel", sel, 1);
    end
    rst = 1'b1;
    req = 4'b0;
    @(negedge clk);
    chk_idle("mid_rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // fairness: two competing requesters with opposite targets, pointer back at 0
    c0 = cyc;
    req = 4'b1001;
    req_src = 4'b0001;
    expect_gnt(c0 + 9, 4'b0001, 1'b1);
    expect_gnt(c0 + 23, 4'b1000, 1'b0);
    expect_gnt(c0 + 37, 4'b0001, 1'b1);
    expect_gnt(c0 + 51, 4'b1000, 1'b0);
    repeat (51) @(negedge clk);
    req = 4'b0;
    repeat (10) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk_idle("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
